mem_access_controller: RTL and testbench
========================================

# mem_access_controller

Registered, parametrised memory-access stage controller for the pipelined processor. It decodes the opcode of the instruction in the memory stage and drives the data-memory write enable and the address-source select. It holds LOAD/STORE instructions for a configurable number of memory wait cycles, stalling upstream stages during that time. It also generates a valid flag for the write-back stage and supports a pipeline flush.

## Interface
Parameters:
- INSTR_WIDTH, 20: instruction width in bits.
- OPCODE_MSB, 19: bit index of the opcode MSB inside the instruction.
- OPCODE_WIDTH, 4: opcode field width; field is instruction[OPCODE_MSB -: OPCODE_WIDTH].
- OP_STORE, 4'b1100: STORE opcode.
- OP_LOAD, 4'b1101: LOAD opcode.
- OP_COPYIN, 4'b1111: COPY INPUT opcode.
- MEM_LATENCY, 2: cycles a LOAD/STORE occupies the stage; legal range 1..16.

Ports (name, direction, width, meaning):
- clock, input, 1: the single clock; all state updates on its rising edge.
- reset, input, 1: synchronous, active-low reset.
- instruction_In, input, INSTR_WIDTH: instruction offered by the execute stage.
- valid_In, input, 1: instruction_In is valid this cycle.
- flush_In, input, 1: discards the held instruction.
- stall_Out, output, 1: the stage is busy; upstream must hold instruction_In and valid_In.
- instruction_Out, output, INSTR_WIDTH: held instruction, forwarded to write-back.
- valid_Out, output, 1: instruction_Out completes this cycle.
- writeEnable_Out, output, 1: data-memory write strobe.
- address_Control_Out, output, 2: address source select; 01 = input copy, 10 = load/store address, 00 = none.

## Operation
- States: IDLE (nothing held) and BUSY (instruction held, with down-counter cnt of width clog2(MEM_LATENCY)+1).
- Accept condition: valid_In && !stall_Out && !flush_In, sampled at the rising edge. On accept, the stage:
  - latches the instruction into instruction_Out;
  - enters BUSY;
  - sets cnt to MEM_LATENCY-1 if the opcode is LOAD/STORE, or to 0 for any other opcode.
- If there is no accept and the stage is in BUSY with cnt==0, it returns to IDLE. If cnt != 0 in BUSY, cnt decrements each cycle.
- Opcode decode is applied to the latched instruction:
  - STORE: address_Control_Out=10.
  - LOAD: address_Control_Out=10.
  - COPY INPUT: address_Control_Out=01.
  - Any other opcode: address_Control_Out=00.
- address_Control_Out holds its value for the whole BUSY occupancy.
- writeEnable_Out is 1 only on the first BUSY cycle of a STORE, giving exactly one write per STORE regardless of MEM_LATENCY. It is 0 otherwise.
- stall_Out = BUSY && cnt != 0. It is decoded from registers only and has no combinational path from the inputs.
- valid_Out = BUSY && cnt == 0, so it pulses for exactly one cycle per instruction.
- Back-to-back operation: while valid_Out=1, stall_Out=0, so a new instruction is accepted at that same edge and there is no bubble.
- flush_In has priority over valid_In. When flush_In is high at an edge, the stage goes to IDLE and all outputs go to 0; a pending write pulse is not re-issued.
- Reset has priority over flush_In and valid_In.

## Timing
- Reset (reset=0 at an edge): state=IDLE, cnt=0, instruction_Out=0, valid_Out=0, writeEnable_Out=0, address_Control_Out=00, stall_Out=0. Reset mid-access aborts the access with no further write pulse.
- Latency: outputs are valid one cycle after the accept edge.
- LOAD/STORE occupies the stage for MEM_LATENCY cycles. stall_Out is high for the first MEM_LATENCY-1 of those cycles, and valid_Out is high on the last one.
- MEM_LATENCY=1: stall_Out is never asserted, and a STORE shows writeEnable_Out and valid_Out in the same cycle.
- Non-memory ops always take 1 cycle.
- Throughput: one non-memory op per cycle, or one LOAD/STORE every MEM_LATENCY cycles.
- valid_In while stall_Out=1 is ignored (no accept). Upstream is required to hold its value.

## Test plan
- Reset: drive reset=0 for 2 cycles with valid_In=1 and a STORE -> all outputs 0, state IDLE. After reset=1 the STORE is accepted on the next edge.
- STORE, MEM_LATENCY=3, instruction 20'hC1234:
  - cycle +1: writeEnable_Out=1, address_Control_Out=10, stall_Out=1;
  - cycle +2: writeEnable_Out=0, stall_Out=1;
  - cycle +3: valid_Out=1, stall_Out=0, instruction_Out=20'hC1234.
- COPY INPUT 20'hF0005 followed by unknown opcode 20'h30001 on consecutive cycles -> two consecutive valid_Out pulses with address_Control_Out 01 then 00, no stall, writeEnable_Out=0 throughout.
- LOAD immediately followed by STORE, MEM_LATENCY=2 -> the STORE is accepted on the edge where the LOAD's valid_Out=1. The STORE's write pulse comes on the very next cycle, with no idle cycle between the two instructions.
- Flush in the second cycle of a MEM_LATENCY=4 STORE -> next cycle all outputs 0 and IDLE, with only one writeEnable_Out pulse seen in total. A new LOAD presented with flush_In=1 is not accepted.
- MEM_LATENCY=1 build, STORE -> writeEnable_Out=1 and valid_Out=1 in the same cycle, stall_Out never 1.

Source files
------------

// File: rtl/mem_access_controller.sv
// Memory-stage controller: decodes the held opcode and drives the write strobe, address select and write-back valid.
// Outputs are registered one cycle after accept; LOAD/STORE hold the stage (stall_Out) for MEM_LATENCY cycles.
module mem_access_controller #(
  parameter int                      INSTR_WIDTH  = 20,
  parameter int                      OPCODE_MSB   = 19,
  parameter int                      OPCODE_WIDTH = 4,
  parameter logic [OPCODE_WIDTH-1:0] OP_STORE     = 4'b1100,
  parameter logic [OPCODE_WIDTH-1:0] OP_LOAD      = 4'b1101,
  parameter logic [OPCODE_WIDTH-1:0] OP_COPYIN    = 4'b1111,
  parameter int                      MEM_LATENCY  = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [INSTR_WIDTH-1:0] instruction_In,
  input  logic                   valid_In,
  input  logic                   flush_In,
  output logic                   stall_Out,
  output logic [INSTR_WIDTH-1:0] instruction_Out,
  output logic                   valid_Out,
  output logic                   writeEnable_Out,
  output logic [1:0]             address_Control_Out
);

  localparam int CW = $clog2(MEM_LATENCY) + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [INSTR_WIDTH-1:0]  instr_q, instr_n;
  logic                    first_q, first_n;

  logic [OPCODE_WIDTH-1:0] op_in, op_q;
  logic                    in_is_mem;
  logic                    accept;

  assign op_in     = instruction_In[OPCODE_MSB -: OPCODE_WIDTH];
  assign op_q      = instr_q[OPCODE_MSB -: OPCODE_WIDTH];
  assign in_is_mem = (op_in == OP_LOAD) || (op_in == OP_STORE);
  // stall_Out is a pure register decode, so accept has no input-to-output loop
  assign accept    = valid_In && !stall_Out && !flush_In;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      instr_q <= '0;
      first_q <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      instr_q <= instr_n;
      first_q <= first_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    instr_n = instr_q;
    first_n = 1'b0;
    if (flush_In) begin
      state_n = IDLE;
      cnt_n   = '0;
      instr_n = '0;
    end else if (accept) begin
      state_n = BUSY;
      cnt_n   = in_is_mem ? CW'(MEM_LATENCY - 1) : '0;
      instr_n = instruction_In;
      first_n = 1'b1;
    end else if (state == BUSY) begin
      if (cnt == '0) begin
        state_n = IDLE;
      end else begin
        cnt_n = cnt - CW'(1);
      end
    end
  end

  always_comb begin
    stall_Out           = 1'b0;
    valid_Out           = 1'b0;
    writeEnable_Out     = 1'b0;
    address_Control_Out = 2'b00;
    instruction_Out     = instr_q;
    if (state == BUSY) begin
      stall_Out       = (cnt != '0);
      valid_Out       = (cnt == '0);
      // first_q marks only the accept cycle, giving one write per STORE
      writeEnable_Out = first_q && (op_q == OP_STORE);
      if ((op_q == OP_STORE) || (op_q == OP_LOAD)) begin
        address_Control_Out = 2'b10;
      end else if (op_q == OP_COPYIN) begin
        address_Control_Out = 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_controller.sv
// Bench for mem_access_controller: four instances with MEM_LATENCY 1..4, directed steps plus a completion scoreboard.
module tb_mem_access_controller;

  typedef struct {
    int          k;
    logic [19:0] ins;
    logic [1:0]  ac;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [19:0] ins_i  [4];
  logic        vld_i  [4];
  logic        fl_i   [4];
  logic        stall_o[4];
  logic [19:0] ins_o  [4];
  logic        vld_o  [4];
  logic        we_o   [4];
  logic [1:0]  ac_o   [4];

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   wcnt[4];
  int   stall_seen0 = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mem_access_controller #(.MEM_LATENCY(g + 1)) dut (
      .clock              (clk),
      .reset              (rst_n),
      .instruction_In     (ins_i[g]),
      .valid_In           (vld_i[g]),
      .flush_In           (fl_i[g]),
      .stall_Out          (stall_o[g]),
      .instruction_Out    (ins_o[g]),
      .valid_Out          (vld_o[g]),
      .writeEnable_Out    (we_o[g]),
      .address_Control_Out(ac_o[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int k, input logic st, input logic vo,
                         input logic we, input logic [1:0] ac);
    chk({tag, ".stall"}, 32'(stall_o[k]), 32'(st));
    chk({tag, ".valid"}, 32'(vld_o[k]), 32'(vo));
    chk({tag, ".we"},    32'(we_o[k]), 32'(we));
    chk({tag, ".addr"},  32'(ac_o[k]), 32'(ac));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [19:0] ins, input logic [1:0] ac);
    exp_t e;
    e.k = k; e.ins = ins; e.ac = ac;
    sb.push_back(e);
  endtask

  // Completion monitor: each valid_Out pops the next expected result
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (we_o[k] === 1'b1) wcnt[k]++;
      if (vld_o[k] === 1'b1) begin
        if (sb.size() == 0) begin
          chk("sb.unexpected_valid", 32'(k), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb.instance", 32'(k), 32'(e.k));
          chk("sb.instr", 32'(ins_o[k]), 32'(e.ins));
          chk("sb.addr", 32'(ac_o[k]), 32'(e.ac));
        end
      end
    end
    if (stall_o[0] === 1'b1) stall_seen0++;
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      ins_i[k] = 20'hC1234;
      vld_i[k] = 1'b1;
      fl_i[k]  = 1'b0;
      wcnt[k]  = 0;
    end
    rst_n = 1'b0;

    // Reset held two cycles with a STORE offered everywhere
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      chk_out("reset", k, 1'b0, 1'b0, 1'b0, 2'b00);
      chk("reset.instr", 32'(ins_o[k]), 32'h0);
    end
    vld_i[0] = 1'b0; vld_i[1] = 1'b0; vld_i[3] = 1'b0;
    push(2, 20'hC1234, 2'b10);
    rst_n = 1'b1;

    // STORE on MEM_LATENCY=3
    tick();
    chk_out("st3.c1", 2, 1'b1, 1'b0, 1'b1, 2'b10);
    vld_i[2] = 1'b0;
    tick();
    chk_out("st3.c2", 2, 1'b1, 1'b0, 1'b0, 2'b10);
    tick();
    chk_out("st3.c3", 2, 1'b0, 1'b1, 1'b0, 2'b10);
    chk("st3.instr", 32'(ins_o[2]), 32'hC1234);

    // COPY INPUT then unknown opcode, back to back
    ins_i[2] = 20'hF0005; vld_i[2] = 1'b1;
    push(2, 20'hF0005, 2'b01);
    tick();
    chk_out("copy", 2, 1'b0, 1'b1, 1'b0, 2'b01);
    ins_i[2] = 20'h30001;
    push(2, 20'h30001, 2'b00);
    tick();
    chk_out("other", 2, 1'b0, 1'b1, 1'b0, 2'b00);
    vld_i[2] = 1'b0;
    tick();
    chk_out("other.idle", 2, 1'b0, 1'b0, 1'b0, 2'b00);

    // LOAD followed by STORE on MEM_LATENCY=2, no bubble
    ins_i[1] = 20'hD0001; vld_i[1] = 1'b1;
    push(1, 20'hD0001, 2'b10);
    tick();
    chk_out("ld.c1", 1, 1'b1, 1'b0, 1'b0, 2'b10);
    ins_i[1] = 20'hC0002;
    push(1, 20'hC0002, 2'b10);
    tick();
    chk_out("ld.c2", 1, 1'b0, 1'b1, 1'b0, 2'b10);
    tick();
    chk_out("st2.c1", 1, 1'b1, 1'b0, 1'b1, 2'b10);
    chk("st2.instr", 32'(ins_o[1]), 32'hC0002);
    vld_i[1] = 1'b0;
    tick();
    chk_out("st2.c2", 1, 1'b0, 1'b1, 1'b0, 2'b10);
    tick();
    chk_out("st2.idle", 1, 1'b0, 1'b0, 1'b0, 2'b00);

    // Flush in the second cycle of a MEM_LATENCY=4 STORE
    ins_i[3] = 20'hC0003; vld_i[3] = 1'b1;
    tick();
    chk_out("fl.c1", 3, 1'b1, 1'b0, 1'b1, 2'b10);
    vld_i[3] = 1'b0;
    tick();
    chk_out("fl.c2", 3, 1'b1, 1'b0, 1'b0, 2'b10);
    fl_i[3] = 1'b1; ins_i[3] = 20'hD0004; vld_i[3] = 1'b1;
    tick();
    chk_out("fl.after", 3, 1'b0, 1'b0, 1'b0, 2'b00);
    chk("fl.instr", 32'(ins_o[3]), 32'h0);
    // Flush while idle must still block the offered LOAD
    tick();
    chk_out("fl.idle_ld", 3, 1'b0, 1'b0, 1'b0, 2'b00);
    fl_i[3] = 1'b0; vld_i[3] = 1'b0;
    tick();
    chk_out("fl.quiet", 3, 1'b0, 1'b0, 1'b0, 2'b00);
    chk("fl.writes", 32'(wcnt[3]), 32'd1);

    // MEM_LATENCY=1 STORE: write and valid together
    ins_i[0] = 20'hC0005; vld_i[0] = 1'b1;
    push(0, 20'hC0005, 2'b10);
    tick();
    chk_out("st1", 0, 1'b0, 1'b1, 1'b1, 2'b10);
    vld_i[0] = 1'b0;
    tick();
    chk_out("st1.idle", 0, 1'b0, 1'b0, 1'b0, 2'b00);

    // Reset in the middle of a MEM_LATENCY=3 STORE
    ins_i[2] = 20'hC0006; vld_i[2] = 1'b1;
    tick();
    chk_out("rst.c1", 2, 1'b1, 1'b0, 1'b1, 2'b10);
    vld_i[2] = 1'b0; rst_n = 1'b0;
    tick();
    chk_out("rst.mid", 2, 1'b0, 1'b0, 1'b0, 2'b00);
    rst_n = 1'b1;
    tick();
    chk_out("rst.after", 2, 1'b0, 1'b0, 1'b0, 2'b00);
    tick();

    chk("sb.empty", 32'(sb.size()), 32'd0);
    chk("st1.writes", 32'(wcnt[0]), 32'd1);
    chk("st1.no_stall", 32'(stall_seen0), 32'd0);
    chk("st2.writes", 32'(wcnt[1]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
